distance_controller: RTL and testbench

//  Sequencing FSM for the horizontal-distance datapath (R1..R7, coefficient ROM, shared multiplier, adder, done flip-flop).
//  It drives the datapath's register load/clear/inc, mux-select and done set/clear controls.

---
 rtl/dist_pkg.sv | 26 ++
 rtl/distance_controller.sv | 145 ++++++++++++++
 tb/tb_distance_controller.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dist_pkg.sv
// Shared definitions for the horizontal-distance controller: state encoding,
// multiplier operand selects and the Q5.11 unity constant.
package dist_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      LOOP  = 3'd2,
      MULX  = 3'd3,
      MULC  = 3'd4,
      FINAL = 3'd5
   } state_t;

   localparam logic [1:0] SEL_XX    = 2'b00;
   localparam logic [1:0] SEL_COEF  = 2'b01;
   localparam logic [1:0] SEL_POW   = 2'b10;
   localparam logic [1:0] SEL_SCALE = 2'b11;

   localparam logic [15:0] ONE = 16'h0800;

   // States that drive the shared multiplier and therefore honour the stall count.
   function automatic logic is_mult_state(input state_t s);
      return (s == INIT) || (s == MULX) || (s == MULC) || (s == FINAL);
   endfunction

endpackage

// File: rtl/distance_controller.sv
// Sequencing FSM for the horizontal-distance datapath: evaluates an 8-term
// series into R6, scales it by v into R7 and raises done.
module distance_controller
   import dist_pkg::*;
#(
   parameter int MULT_WAIT = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_R4_greater_than_eight,
   output logic busy,
   output logic ld_R1,
   output logic ld_R2,
   output logic ld_R4,
   output logic ld_R5,
   output logic ld_R6,
   output logic ld_R7,
   output logic clr_R1,
   output logic clr_R2,
   output logic clr_R4,
   output logic clr_R5,
   output logic clr_R6,
   output logic clr_R7,
   output logic inc_R4,
   output logic set_done,
   output logic clear_done,
   output logic S1,
   output logic S0,
   output logic S5
);

   localparam logic [3:0] WAIT_LAST = 4'(MULT_WAIT);

   state_t     state_q, state_d;
   logic [3:0] wait_q, wait_d;
   logic       hold_last;

   assign hold_last = (wait_q == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         wait_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_d     = 4'd0;
      busy       = 1'b0;
      ld_R1      = 1'b0;
      ld_R2      = 1'b0;
      ld_R4      = 1'b0;
      ld_R5      = 1'b0;
      ld_R6      = 1'b0;
      ld_R7      = 1'b0;
      clr_R1     = 1'b0;
      clr_R2     = 1'b0;
      clr_R4     = 1'b0;
      clr_R5     = 1'b0;
      clr_R6     = 1'b0;
      clr_R7     = 1'b0;
      inc_R4     = 1'b0;
      set_done   = 1'b0;
      clear_done = 1'b0;
      S1         = 1'b0;
      S0         = 1'b0;
      S5         = 1'b0;

      // Reset forces the datapath clear regardless of the registered state.
      if (!reset) begin
         clr_R1     = 1'b1;
         clr_R2     = 1'b1;
         clr_R4     = 1'b1;
         clr_R5     = 1'b1;
         clr_R6     = 1'b1;
         clr_R7     = 1'b1;
         clear_done = 1'b1;
      end else begin
         busy = (state_q != IDLE);
         if (is_mult_state(state_q) && !hold_last) begin
            wait_d = wait_q + 4'd1;
         end

         case (state_q)
            IDLE: begin
               if (start) state_d = INIT;
            end
            INIT: begin
               {S1, S0} = SEL_XX;
               S5       = 1'b0;
               if (hold_last) begin
                  ld_R1      = 1'b1;
                  ld_R2      = 1'b1;
                  ld_R5      = 1'b1;
                  clr_R4     = 1'b1;
                  clr_R6     = 1'b1;
                  clr_R7     = 1'b1;
                  clear_done = 1'b1;
                  state_d    = LOOP;
               end
            end
            LOOP: begin
               if (is_R4_greater_than_eight) begin
                  state_d = FINAL;
               end else begin
                  ld_R6   = 1'b1;
                  state_d = MULX;
               end
            end
            MULX: begin
               {S1, S0} = SEL_POW;
               S5       = 1'b1;
               if (hold_last) begin
                  ld_R5   = 1'b1;
                  state_d = MULC;
               end
            end
            MULC: begin
               {S1, S0} = SEL_COEF;
               S5       = 1'b1;
               if (hold_last) begin
                  ld_R5   = 1'b1;
                  inc_R4  = 1'b1;
                  state_d = LOOP;
               end
            end
            FINAL: begin
               {S1, S0} = SEL_SCALE;
               if (hold_last) begin
                  ld_R7    = 1'b1;
                  set_done = 1'b1;
                  state_d  = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_distance_controller.sv
// Bench for distance_controller: two instances (MULT_WAIT 0 and 2) each driving
// a behavioural datapath, checked against a plain-arithmetic series model.
module tb_distance_controller;
   import dist_pkg::*;

   localparam int B_BUSY = 18, B_LD1 = 17, B_LD2 = 16, B_LD4 = 15, B_LD5 = 14,
                  B_LD6 = 13, B_LD7 = 12, B_CLR1 = 11, B_CLR2 = 10, B_CLR4 = 9,
                  B_CLR5 = 8, B_CLR6 = 7, B_CLR7 = 6, B_INC = 5, B_SET = 4,
                  B_CLRD = 3, B_S1 = 2, B_S0 = 1, B_S5 = 0;

   localparam logic [18:0] RST_W = (19'd1 << B_CLR1) | (19'd1 << B_CLR2) | (19'd1 << B_CLR4) |
                                   (19'd1 << B_CLR5) | (19'd1 << B_CLR6) | (19'd1 << B_CLR7) |
                                   (19'd1 << B_CLRD);
   localparam logic [18:0] INIT_W = (19'd1 << B_BUSY) | (19'd1 << B_LD1) | (19'd1 << B_LD2) |
                                    (19'd1 << B_LD5) | (19'd1 << B_CLR4) | (19'd1 << B_CLR6) |
                                    (19'd1 << B_CLR7) | (19'd1 << B_CLRD);

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start_v [2];
   logic signed [15:0] x = '0, v = '0;
   logic [18:0] ow [2];
   logic signed [15:0] res [2];
   logic done_v [2];

   logic [18:0] samp [0:127];
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   function automatic logic signed [15:0] mulq(input logic signed [15:0] a, input logic signed [15:0] b);
      logic signed [31:0] p;
      p = a * b;
      return p[26:11];
   endfunction

   function automatic logic signed [15:0] rom(input int k);
      case (k)
         0: return 16'sh0800;
         1: return -16'sh0400;
         2: return 16'sh0155;
         3: return -16'sh0080;
         4: return 16'sh0022;
         5: return -16'sh0007;
         6: return 16'sh0001;
         default: return 16'sh0000;
      endcase
   endfunction

   // Series sum_{k=0..7} t_k with t_0 = 1 and t_{k+1} = t_k * x^2 * c_k, then scaled by v.
   function automatic logic signed [15:0] ref_result(input logic signed [15:0] xi, input logic signed [15:0] vi);
      logic signed [15:0] x2, term, acc;
      x2   = mulq(xi, xi);
      term = ONE;
      acc  = '0;
      for (int k = 0; k < 8; k++) begin
         acc  = acc + term;
         term = mulq(mulq(term, x2), rom(k));
      end
      return mulq(acc, vi);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic busy, ld_R1, ld_R2, ld_R4, ld_R5, ld_R6, ld_R7;
      logic clr_R1, clr_R2, clr_R4, clr_R5, clr_R6, clr_R7;
      logic inc_R4, set_done, clear_done, S1, S0, S5, flag;
      logic signed [15:0] R1 = '0, R2 = '0, R5 = '0, R6 = '0, R7 = '0;
      logic [3:0] R4 = '0;
      logic done = 1'b0;
      logic signed [15:0] opa, opb, prod;

      distance_controller #(.MULT_WAIT(2 * g)) u_dut (
         .clk(clk), .reset(reset), .start(start_v[g]), .is_R4_greater_than_eight(flag),
         .busy(busy), .ld_R1(ld_R1), .ld_R2(ld_R2), .ld_R4(ld_R4), .ld_R5(ld_R5),
         .ld_R6(ld_R6), .ld_R7(ld_R7), .clr_R1(clr_R1), .clr_R2(clr_R2), .clr_R4(clr_R4),
         .clr_R5(clr_R5), .clr_R6(clr_R6), .clr_R7(clr_R7), .inc_R4(inc_R4),
         .set_done(set_done), .clear_done(clear_done), .S1(S1), .S0(S0), .S5(S5)
      );

      assign flag = (R4 >= 4'd8);

      always_comb begin
         opa = x;
         opb = x;
         case ({S1, S0})
            2'b01: begin opa = R5; opb = rom(int'(R4)); end
            2'b10: begin opa = R5; opb = R1; end
            2'b11: begin opa = R6; opb = R2; end
            default: ;
         endcase
         prod = mulq(opa, opb);
      end

      always @(posedge clk) begin
         if (clr_R1) R1 <= '0; else if (ld_R1) R1 <= prod;
         if (clr_R2) R2 <= '0; else if (ld_R2) R2 <= v;
         if (clr_R4) R4 <= '0; else if (inc_R4) R4 <= R4 + 4'd1;
         if (clr_R5) R5 <= '0; else if (ld_R5) R5 <= S5 ? prod : ONE;
         if (clr_R6) R6 <= '0; else if (ld_R6) R6 <= R6 + R5;
         if (clr_R7) R7 <= '0; else if (ld_R7) R7 <= prod;
         if (clear_done) done <= 1'b0; else if (set_done) done <= 1'b1;
      end

      assign ow[g] = {busy, ld_R1, ld_R2, ld_R4, ld_R5, ld_R6, ld_R7, clr_R1, clr_R2, clr_R4,
                      clr_R5, clr_R6, clr_R7, inc_R4, set_done, clear_done, S1, S0, S5};
      assign res[g]    = R7;
      assign done_v[g] = done;
   end

   // Edge 0 is the edge after which start is raised; samp[e] holds the controls landing at edge e.
   task automatic observe(input int i, input int n, input int mode);
      @(posedge clk); #1;
      start_v[i] = 1'b1;
      for (int e = 1; e <= n; e++) begin
         @(negedge clk);
         samp[e] = ow[i];
         @(posedge clk); #1;
         start_v[i] = (mode == 2) || ((mode == 1) && (e == 5 || e == 15));
      end
      start_v[i] = 1'b0;
   endtask

   function automatic int count_bit(input int b, input int n);
      int c = 0;
      for (int e = 1; e <= n; e++) if (samp[e][b]) c++;
      return c;
   endfunction

   function automatic int nth_edge(input int b, input int n, input int k);
      int c = 0;
      for (int e = 1; e <= n; e++) begin
         if (samp[e][b]) begin
            if (c == k) return e;
            c++;
         end
      end
      return -1;
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (ow[i] !== RST_W) begin
            errors++;
            $display("FAIL reset_controls[%0d]: got %05h expected %05h", i, ow[i], RST_W);
         end
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (ow[i] !== 19'd0) begin
            errors++;
            $display("FAIL idle_controls[%0d]: got %05h expected 00000", i, ow[i]);
         end
      end
   endtask

   task automatic test_run(input string name, input logic signed [15:0] xi, input logic signed [15:0] vi);
      logic signed [15:0] exp_r;
      x = xi;
      v = vi;
      exp_r = ref_result(xi, vi);
      observe(0, 34, 0);
      checks++;
      if (samp[2] !== INIT_W) begin
         errors++; $display("FAIL %s init_word: got %05h expected %05h", name, samp[2], INIT_W);
      end
      checks++;
      if (count_bit(B_LD6, 34) !== 8) begin
         errors++; $display("FAIL %s ld_R6_count: got %0d expected 8", name, count_bit(B_LD6, 34));
      end
      checks++;
      if (count_bit(B_INC, 34) !== 8) begin
         errors++; $display("FAIL %s inc_R4_count: got %0d expected 8", name, count_bit(B_INC, 34));
      end
      checks++;
      if (count_bit(B_LD4, 34) !== 0) begin
         errors++; $display("FAIL %s ld_R4_count: got %0d expected 0", name, count_bit(B_LD4, 34));
      end
      checks++;
      if (nth_edge(B_SET, 34, 0) !== 28 || count_bit(B_SET, 34) !== 1) begin
         errors++;
         $display("FAIL %s set_done_edge: got %0d (count %0d) expected 28 (count 1)",
                  name, nth_edge(B_SET, 34, 0), count_bit(B_SET, 34));
      end
      checks++;
      if (samp[28][B_BUSY] !== 1'b1 || samp[29][B_BUSY] !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_fall: got %b%b expected 10", name, samp[28][B_BUSY], samp[29][B_BUSY]);
      end
      checks++;
      if (done_v[0] !== 1'b1) begin
         errors++; $display("FAIL %s done: got %b expected 1", name, done_v[0]);
      end
      checks++;
      if (res[0] !== exp_r) begin
         errors++; $display("FAIL %s final_result: got %04h expected %04h", name, res[0], exp_r);
      end
   endtask

   task automatic test_back_to_back();
      int waited;
      x = 16'sh0200;
      v = 16'sh0800;
      observe(0, 34, 1);
      checks++;
      if (count_bit(B_SET, 34) !== 1 || nth_edge(B_SET, 34, 0) !== 28) begin
         errors++;
         $display("FAIL busy_start_ignored: got %0d runs done at %0d expected 1 run at 28",
                  count_bit(B_SET, 34), nth_edge(B_SET, 34, 0));
      end
      observe(0, 58, 2);
      checks++;
      if (nth_edge(B_SET, 58, 0) !== 28 || nth_edge(B_SET, 58, 1) !== 56) begin
         errors++;
         $display("FAIL held_start_runs: got %0d,%0d expected 28,56",
                  nth_edge(B_SET, 58, 0), nth_edge(B_SET, 58, 1));
      end
      checks++;
      if (samp[29][B_BUSY] !== 1'b0 || samp[30] !== INIT_W) begin
         errors++;
         $display("FAIL held_start_restart: got busy29=%b word30=%05h expected 0 and %05h",
                  samp[29][B_BUSY], samp[30], INIT_W);
      end
      waited = 0;
      while (ow[0][B_BUSY] === 1'b1 && waited < 100) begin
         @(posedge clk); #1;
         waited++;
      end
      checks++;
      if (ow[0][B_BUSY] !== 1'b0) begin
         errors++; $display("FAIL drain_timeout: got busy=%b expected 0", ow[0][B_BUSY]);
      end
      checks++;
      if (res[0] !== ref_result(x, v)) begin
         errors++; $display("FAIL held_start_result: got %04h expected %04h", res[0], ref_result(x, v));
      end
   endtask

   task automatic test_reset_mid();
      x = 16'sh0300;
      v = 16'sh0c00;
      @(posedge clk); #1;
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      repeat (8) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (ow[0] !== RST_W) begin
         errors++; $display("FAIL midrun_reset_controls: got %05h expected %05h", ow[0], RST_W);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (ow[0] !== 19'd0 || done_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset_idle: got %05h done=%b expected 00000 done=0", ow[0], done_v[0]);
      end
      test_run("after_reset", 16'sh0300, 16'sh0c00);
   endtask

   task automatic test_mult_wait();
      int viol;
      logic signed [15:0] exp_r;
      x = 16'($urandom_range(0, 2047)) - 16'sh0400;
      v = 16'($urandom_range(0, 4095));
      exp_r = ref_result(x, v);
      observe(1, 70, 0);
      checks++;
      if (nth_edge(B_SET, 70, 0) !== 64) begin
         errors++; $display("FAIL mw2_set_done_edge: got %0d expected 64", nth_edge(B_SET, 70, 0));
      end
      checks++;
      if (samp[2] !== (19'd1 << B_BUSY) || samp[4] !== INIT_W) begin
         errors++;
         $display("FAIL mw2_init_hold: got %05h/%05h expected %05h/%05h",
                  samp[2], samp[4], 19'd1 << B_BUSY, INIT_W);
      end
      viol = 0;
      for (int e = 3; e <= 70; e++) begin
         if (samp[e][B_LD5]) begin
            for (int d = 1; d <= 2; d++) begin
               if (samp[e-d][B_LD5] !== 1'b0 || samp[e-d][2:0] !== samp[e][2:0]) viol++;
            end
         end
      end
      checks++;
      if (viol !== 0 || count_bit(B_LD5, 70) !== 17) begin
         errors++;
         $display("FAIL mw2_ld_R5_stall: got %0d violations, %0d loads expected 0, 17",
                  viol, count_bit(B_LD5, 70));
      end
      checks++;
      if (count_bit(B_LD6, 70) !== 8 || count_bit(B_INC, 70) !== 8) begin
         errors++;
         $display("FAIL mw2_counts: got ld_R6=%0d inc_R4=%0d expected 8,8",
                  count_bit(B_LD6, 70), count_bit(B_INC, 70));
      end
      checks++;
      if (done_v[1] !== 1'b1 || res[1] !== exp_r) begin
         errors++;
         $display("FAIL mw2_result: got done=%b %04h expected done=1 %04h", done_v[1], res[1], exp_r);
      end
   endtask

   initial begin
      start_v[0] = 1'b0;
      start_v[1] = 1'b0;
      test_reset();
      test_run("unity_v", 16'sh0000, 16'sh0800);
      test_run("double_v", 16'sh0000, 16'sh1000);
      for (int r = 0; r < 3; r++) begin
         test_run("random", 16'($urandom_range(0, 2047)) - 16'sh0400, 16'($urandom_range(0, 4095)));
      end
      test_back_to_back();
      test_reset_mid();
      test_mult_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
